dp_mem_banked: RTL
==================

DP_MEM_BANKED -- requirements
Module: dp_mem_banked

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, address width in bits.
REQ-003 SHALL have parameter MEM_SIZE, default 48, number of words; must satisfy MEM_SIZE <= 2**ADDR_WIDTH.
REQ-004 SHALL have parameter RD_LATENCY, default 1, read latency in cycles; legal values are 1 and 2.
REQ-005 SHALL have port clk  in  1  the single clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port clear_req  in  1  pulse that starts a zeroing sweep of the whole memory.
REQ-008 SHALL have port busy  out  1  high while a clear sweep runs.
REQ-009 SHALL have port write_en  in  1  write request.
REQ-010 SHALL have port write_address  in  ADDR_WIDTH  write word address.
REQ-011 SHALL have port write_strb  in  DATA_WIDTH/8  per-byte write enable.
REQ-012 SHALL have port data_in  in  DATA_WIDTH  write data.
REQ-013 SHALL have port read_en  in  1  read request.
REQ-014 SHALL have port read_address  in  ADDR_WIDTH  read word address.
REQ-015 SHALL have port data_out  out  DATA_WIDTH  registered read data.
REQ-016 SHALL have port data_valid  out  1  data_out holds the result of an accepted read.
REQ-017 SHALL have port addr_err  out  1  one-cycle pulse: an accepted access addressed a word >= MEM_SIZE.

Function
REQ-018 SHALL, when write_en=1 and busy=0, update only the bytes of mem[write_address] whose write_strb bit is 1 at the clock edge.
REQ-019 SHALL, when read_en=1 and busy=0, present mem[read_address] on data_out with data_valid=1 exactly RD_LATENCY cycles after the request edge.
REQ-020 SHALL keep data_out unchanged while data_valid=0; data_valid SHALL be 0 in every cycle with no read completing.
REQ-021 SHALL, on read and write to the same in-range address in one cycle, return write-first data: strobed bytes from data_in, other bytes from the old word.
REQ-022 SHALL ignore writes with address >= MEM_SIZE, return all-zero data with data_valid=1 for reads with address >= MEM_SIZE, and pulse addr_err the cycle after either such accepted request.
REQ-023 SHALL implement a clear FSM with states IDLE and CLEAR; IDLE->CLEAR on clear_req=1; CLEAR writes zero to word index 0,1,...,MEM_SIZE-1, one per cycle; CLEAR->IDLE after writing MEM_SIZE-1.
REQ-024 SHALL assert busy for exactly MEM_SIZE cycles per sweep, starting the cycle after clear_req is sampled.
REQ-025 SHALL ignore write_en, read_en and clear_req while busy=1; reads already in the pipeline when the sweep starts SHALL still complete with their pre-clear data.
REQ-026 SHALL give clear_req priority over a same-cycle write/read in IDLE: sweep starts, the same-cycle access is dropped.
REQ-027 SHALL hold the sweep counter at ADDR_WIDTH bits and never wrap beyond MEM_SIZE-1.

Reset
REQ-028 SHALL, while rst=1, force data_out=0, data_valid=0, addr_err=0, busy=0, FSM=IDLE, sweep counter=0, and flush the read pipeline.
REQ-029 SHALL NOT reset memory contents; reset during CLEAR leaves already-zeroed words zero and the rest unchanged.
REQ-030 SHALL initialise every memory word to zero at simulation start.

Structure
REQ-031 SHALL place the FSM state encoding (IDLE, CLEAR) and the legal RD_LATENCY values in the shared package.
REQ-032 SHALL be built around one sub-module, dp_mem_core: a strobed simple dual-port array with one registered read port and no reset; control, bypass, range check and pipeline live in the top level.

Verification
REQ-033 SHALL be checked by: write 0xAABBCCDD strobe 4'b1111 at addr 5, then read addr 5 -> data_out=0xAABBCCDD, data_valid=1 after RD_LATENCY cycles.
REQ-034 SHALL be checked by: addr 7 holds 0x11223344, write 0xFFFFFFFF strobe 4'b0101 with read of addr 7 in the same cycle -> data_out=0x11FF33FF.
REQ-035 SHALL be checked by: MEM_SIZE=48, write addr 50 then read addr 50 -> addr_err pulses twice, read returns 0x00000000, mem[50 mod 48] unchanged.
REQ-036 SHALL be checked by: fill memory, clear_req pulse -> busy high exactly 48 cycles, reads during busy give no data_valid, afterwards every address reads 0.
REQ-037 SHALL be checked by: assert rst at sweep cycle 10 -> busy=0 next edge, words 0..9 read 0, words 10..47 keep their prior values.
REQ-038 SHALL be checked with RD_LATENCY=1 and RD_LATENCY=2 using back-to-back reads of addrs 0..3 -> four consecutive data_valid cycles, data in order.

Source files
------------

// File: rtl/dp_mem_banked_pkg.sv
// Shared definitions for the banked dual-port memory with clear sweep.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dp_mem_banked_pkg;

    // Clear sequencer states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    // Supported read latencies: data straight from the array register, or one extra output stage.
    localparam int RD_LAT_SHORT = 1;
    localparam int RD_LAT_LONG  = 2;

endpackage

// File: rtl/dp_mem_core.sv
// Strobed simple dual-port word array, one write port, one registered read port, no reset.
// Latency: read data valid one cycle after rd_en_i; writes land at the clock edge.
// Backpressure: none; every enabled access is performed (caller guarantees in-range addresses).
module dp_mem_core #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int MEM_SIZE   = 48
) (
    input  logic                    clk_i,
    input  logic                    wr_en_i,
    input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic [DATA_WIDTH/8-1:0] wr_strb_i,
    input  logic [DATA_WIDTH-1:0]   wr_dat_i,
    input  logic                    rd_en_i,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
    output logic [DATA_WIDTH-1:0]   rd_dat_o
);
    localparam int NB = DATA_WIDTH / 8;

    // Contents start at zero; never touched by reset.
    logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE] = '{default: '0};
    logic [DATA_WIDTH-1:0] rd_dat_q;

    // Byte-strobed write.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_strb_i[b]) begin
                    mem_q[wr_addr_i][b*8 +: 8] <= wr_dat_i[b*8 +: 8];
                end
            end
        end
    end

    // Registered read; returns the pre-write word on a same-address collision.
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_dat_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/dp_mem_banked.sv
// Dual-port memory with write-first bypass, range check, zeroing sweep and 1/2-cycle read pipeline.
// Latency: read data RD_LATENCY cycles after request; clear sweep takes MEM_SIZE cycles.
// Backpressure: busy high during a sweep; accesses and clear requests are dropped while busy.
module dp_mem_banked
    import dp_mem_banked_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int MEM_SIZE   = 48,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_req,
    output logic                    busy,
    input  logic                    write_en,
    input  logic [ADDR_WIDTH-1:0]   write_address,
    input  logic [DATA_WIDTH/8-1:0] write_strb,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    read_en,
    input  logic [ADDR_WIDTH-1:0]   read_address,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    data_valid,
    output logic                    addr_err
);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(MEM_SIZE - 1);
    localparam logic [ADDR_WIDTH:0]   MEM_SIZE_W = (ADDR_WIDTH + 1)'(MEM_SIZE);

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    logic                  acc_ok, wr_acc, rd_acc, wr_in, rd_in;
    logic [DATA_WIDTH-1:0] wr_mask;

    logic                    core_wr_en;
    logic [ADDR_WIDTH-1:0]   core_wr_addr;
    logic [DATA_WIDTH/8-1:0] core_wr_strb;
    logic [DATA_WIDTH-1:0]   core_wr_dat;
    logic [DATA_WIDTH-1:0]   core_rd_dat;

    logic                  s1_vld_q, s1_oor_q, byp_vld_q, err_q;
    logic [DATA_WIDTH-1:0] byp_mask_q, byp_dat_q, byp_m, rd_merged;

    // Clear sequencer next state: walk every word once, then return to idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Sequencer state and sweep counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == ST_CLEAR);

    // A clear request in idle wins over any same-cycle access.
    assign acc_ok = !busy && !clear_req;
    assign wr_acc = acc_ok && write_en;
    assign rd_acc = acc_ok && read_en;
    assign wr_in  = ({1'b0, write_address} < MEM_SIZE_W);
    assign rd_in  = ({1'b0, read_address} < MEM_SIZE_W);

    // Expand byte strobes to a bit mask for the bypass merge.
    always_comb begin
        wr_mask = '0;
        for (int b = 0; b < NB; b++) begin
            wr_mask[b*8 +: 8] = {8{write_strb[b]}};
        end
    end

    // The sweep owns the write port while busy.
    assign core_wr_en   = busy || (wr_acc && wr_in);
    assign core_wr_addr = busy ? cnt_q : write_address;
    assign core_wr_strb = busy ? '1 : write_strb;
    assign core_wr_dat  = busy ? '0 : data_in;

    dp_mem_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_SIZE   (MEM_SIZE)
    ) u_core (
        .clk_i     (clk),
        .wr_en_i   (core_wr_en),
        .wr_addr_i (core_wr_addr),
        .wr_strb_i (core_wr_strb),
        .wr_dat_i  (core_wr_dat),
        .rd_en_i   (rd_acc && rd_in),
        .rd_addr_i (read_address),
        .rd_dat_o  (core_rd_dat)
    );

    // First read stage: remember out-of-range reads and same-address write bytes to overlay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_oor_q   <= 1'b0;
            byp_vld_q  <= 1'b0;
            byp_mask_q <= '0;
            byp_dat_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            s1_vld_q   <= rd_acc;
            s1_oor_q   <= rd_acc && !rd_in;
            byp_vld_q  <= rd_acc && wr_acc && rd_in && (read_address == write_address);
            byp_mask_q <= wr_mask;
            byp_dat_q  <= data_in;
            err_q      <= (wr_acc && !wr_in) || (rd_acc && !rd_in);
        end
    end

    assign addr_err  = err_q;
    assign byp_m     = byp_vld_q ? byp_mask_q : '0;
    assign rd_merged = s1_oor_q ? '0 : ((core_rd_dat & ~byp_m) | (byp_dat_q & byp_m));

    if (RD_LATENCY == RD_LAT_LONG) begin : g_lat2
        logic [DATA_WIDTH-1:0] out_q;
        logic                  vld_q;

        // Extra output stage; only loads on a completing read so data holds otherwise.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_q <= '0;
                vld_q <= 1'b0;
            end else begin
                vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    out_q <= rd_merged;
                end
            end
        end

        assign data_out   = out_q;
        assign data_valid = vld_q;
    end else begin : g_lat1
        logic [DATA_WIDTH-1:0] hold_q;

        // Keeps the last delivered word visible between reads.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hold_q <= '0;
            end else if (s1_vld_q) begin
                hold_q <= rd_merged;
            end
        end

        assign data_out   = s1_vld_q ? rd_merged : hold_q;
        assign data_valid = s1_vld_q;
    end

endmodule
